// File: rtl/uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Purpose  : TX handshake between the UART register controller and the engine.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
  logic [31:0] i_tx_data;
  logic        i_tx_start;
  logic        o_tx_start_clear;
  logic        o_tx_busy;
  logic        o_tx_done;
  logic        o_txd;

  modport master (
    output i_tx_data, i_tx_start,
    input  o_tx_start_clear, o_tx_busy, o_tx_done, o_txd
  );

  modport slave (
    input  i_tx_data, i_tx_start,
    output o_tx_start_clear, o_tx_busy, o_tx_done, o_txd
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : UART serial transmitter (start, 8N/8P, 1-2 stop) with a
//            level-start / pulse-clear handshake to the register controller.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
  parameter int BAUD_DIV   = 434,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave tx
);

  localparam int              C_STOP_LEN  = STOP_BITS * BAUD_DIV;
  localparam int              C_CNT_W     = $clog2(C_STOP_LEN);
  localparam logic [C_CNT_W-1:0] C_BIT_LAST  = C_CNT_W'(BAUD_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_STOP_LAST = C_CNT_W'(C_STOP_LEN - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
  localparam logic            C_PAR_EN    = (PARITY_EN != 0);
  localparam logic            C_ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_baud_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_parity;
  logic                 r_txd;
  logic                 r_busy;
  logic                 r_clear;
  logic                 r_done;
  logic                 w_bit_end;
  logic                 w_unused_data_hi;

  assign w_bit_end        = (r_baud_cnt == C_BIT_LAST);
  assign w_unused_data_hi = ^tx.i_tx_data[31:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_clear    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_txd      <= 1'b1;
          r_busy     <= 1'b0;
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          if (tx.i_tx_start) begin
            r_shift  <= tx.i_tx_data[7:0];
            r_parity <= (^tx.i_tx_data[7:0]) ^ C_ODD;
            r_state  <= S_START;
            r_clear  <= 1'b1;
            r_busy   <= 1'b1;
            r_txd    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_txd      <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              if (C_PAR_EN) begin
                r_state <= S_PARITY;
                r_txd   <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              // Shift right so the next bit to send is always at [1] here.
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= S_STOP;
            r_txd      <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
          end
        end
        S_STOP: begin
          // One counter spans all stop bits; done lands on the first IDLE cycle.
          if (r_baud_cnt == C_STOP_LAST) begin
            r_baud_cnt <= '0;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_txd      <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.o_txd            = r_txd;
  assign tx.o_tx_busy        = r_busy;
  assign tx.o_tx_start_clear = r_clear;
  assign tx.o_tx_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_engine
// Purpose  : Scoreboard bench for uart_tx_engine across four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

  localparam int B = 4;
  localparam int N = 4;

  typedef struct {
    string wave;
    int    gap;
  } frame_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_drv  [N];
  logic        start_drv [N];
  logic        txd_o     [N];
  logic        busy_o    [N];
  logic        clr_o     [N];
  logic        done_o    [N];
  frame_t      exp_q     [N][$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  function automatic void check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endfunction

  // dut0: plain, dut1: even parity, dut2: odd parity, dut3: two stop bits
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int STOPS = (g == 3) ? 2 : 1;
    localparam int PEN   = (g == 1 || g == 2) ? 1 : 0;
    localparam int PODD  = (g == 2) ? 1 : 0;

    uart_tx_if u_if ();
    assign u_if.i_tx_data  = data_drv[g];
    assign u_if.i_tx_start = start_drv[g];
    assign txd_o[g]  = u_if.o_txd;
    assign busy_o[g] = u_if.o_tx_busy;
    assign clr_o[g]  = u_if.o_tx_start_clear;
    assign done_o[g] = u_if.o_tx_done;

    uart_tx_engine #(
      .BAUD_DIV  (B),
      .STOP_BITS (STOPS),
      .PARITY_EN (PEN),
      .PARITY_ODD(PODD)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .tx   (u_if)
    );

    logic   wave_q[$];
    int     idle_cnt = 1000;
    int     clr_cnt  = 0;
    int     gap_seen = -1;
    int     mism;
    int     n_bits;
    logic   exp_bit;
    frame_t f;

    always @(negedge clk) begin
      if (!rst_n) begin
        wave_q.delete();
        idle_cnt = 1000;
        clr_cnt  = 0;
      end else begin
        if (clr_o[g]) clr_cnt++;
        if (busy_o[g]) begin
          if (wave_q.size() == 0) gap_seen = idle_cnt;
          wave_q.push_back(txd_o[g]);
          idle_cnt = 0;
        end else begin
          idle_cnt++;
        end
        if (done_o[g]) begin
          if (exp_q[g].size() == 0) begin
            check("unexpected_done", g, 32'(done_o[g]), 32'd0);
          end else begin
            f      = exp_q[g].pop_front();
            n_bits = f.wave.len();
            check("busy_cycles", g, 32'(wave_q.size()), 32'(n_bits * B));
            mism = -1;
            for (int k = 0; k < wave_q.size(); k++) begin
              exp_bit = (k / B < n_bits) ? (f.wave[k / B] == "1") : 1'b1;
              if (wave_q[k] !== exp_bit && mism < 0) mism = k;
            end
            n_checks++;
            if (mism >= 0) begin
              n_fail++;
              $display("FAIL txd_wave dut%0d: cycle %0d got %b expected %b (frame %s)",
                       g, mism, wave_q[mism], f.wave[mism / B] == "1", f.wave);
            end
            check("clear_pulses", g, 32'(clr_cnt), 32'd1);
            check("busy_at_done", g, 32'(busy_o[g]), 32'd0);
            check("txd_at_done", g, 32'(txd_o[g]), 32'd1);
            if (f.gap >= 0) check("idle_gap", g, 32'(gap_seen), 32'(f.gap));
          end
          wave_q.delete();
          clr_cnt = 0;
        end
      end
    end
  end

  task automatic wait_clear(int k);
    int t = 0;
    while (clr_o[k] !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("clear_seen", k, 32'(clr_o[k]), 32'd1);
  endtask

  task automatic wait_drain(int k);
    int t = 0;
    while (exp_q[k].size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("frames_drained", k, 32'(exp_q[k].size()), 32'd0);
  endtask

  task automatic send(int k, logic [31:0] d, string w, int gap);
    exp_q[k].push_back('{w, gap});
    data_drv[k]  = d;
    start_drv[k] = 1'b1;
    wait_clear(k);
    start_drv[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      data_drv[k]  = '0;
      start_drv[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      check("reset_txd", k, 32'(txd_o[k]), 32'd1);
      check("reset_busy", k, 32'(busy_o[k]), 32'd0);
      check("reset_clear", k, 32'(clr_o[k]), 32'd0);
      check("reset_done", k, 32'(done_o[k]), 32'd0);
    end

    // Single frames per configuration
    send(0, 32'h0000_00A5, "0101001011", -1);  wait_drain(0);
    send(1, 32'h0000_0007, "01110000011", -1); wait_drain(1);
    send(1, 32'h0000_0000, "00000000001", -1); wait_drain(1);
    send(2, 32'h0000_0007, "01110000001", -1); wait_drain(2);
    send(3, 32'h0000_00FF, "01111111111", -1); wait_drain(3);

    // Request and data change mid-frame: held until the done cycle
    send(0, 32'h0000_0096, "0011010011", -1);
    repeat (9) @(posedge clk); #1;
    exp_q[0].push_back('{"0010010001", 1});
    data_drv[0]  = 32'hDEAD_BE12;
    start_drv[0] = 1'b1;
    wait_clear(0);
    start_drv[0] = 1'b0;
    wait_drain(0);

    // Back-to-back with start held high
    exp_q[0].push_back('{"0101010101", -1});
    exp_q[0].push_back('{"0010101011", 1});
    data_drv[0]  = 32'h0000_0055;
    start_drv[0] = 1'b1;
    wait_clear(0);
    data_drv[0] = 32'h0000_00AA;
    @(posedge clk); #1;
    wait_clear(0);
    start_drv[0] = 1'b0;
    wait_drain(0);

    // Reset during DATA bit 3 (0xF0 bit 3 is 0, so txd is low beforehand)
    data_drv[0]  = 32'h0000_00F0;
    start_drv[0] = 1'b1;
    wait_clear(0);
    start_drv[0] = 1'b0;
    repeat (17) @(posedge clk); #1;
    check("pre_reset_txd", 0, 32'(txd_o[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_txd", 0, 32'(txd_o[0]), 32'd1);
    check("async_reset_busy", 0, 32'(busy_o[0]), 32'd0);
    check("async_reset_done", 0, 32'(done_o[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk); #1;
    check("post_reset_busy", 0, 32'(busy_o[0]), 32'd0);
    send(0, 32'h0000_003C, "0001111001", -1);
    wait_drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
